mem2sdp: RTL and testbench

//  Serial debug port host: converts one mem_req_t transaction into an SDP command frame on sdp_do and

---
 rtl/mem2sdp.sv | 257 +++++++++++++++++++++++++
 tb/tb_mem2sdp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2sdp.sv
// Serial debug port host: frames one memory request onto sdp_do and decodes the
// target's response from sdp_di. One transaction in flight at a time.

package mem2sdp_pkg;
  typedef struct packed {
    logic        req_type;   // 1 = write, 0 = read
    logic [31:0] req_addr;
    logic [3:0]  req_mask;
    logic [31:0] req_data;
    logic        req_burst;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_data;
  } mem_resp_t;
endpackage

module mem2sdp
  import mem2sdp_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int TIMEOUT  = 4096,
  parameter int GAP_BITS = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       mem_req_valid,
  output logic       mem_req_ready,
  input  mem_req_t   mem_req,
  output logic       mem_resp_valid,
  input  logic       mem_resp_ready,
  output mem_resp_t  mem_resp,
  output logic       resp_err,
  output logic [1:0] err_code,
  output logic       sdp_ck,
  output logic       sdp_do,
  input  logic       sdp_di,
  output logic       sdp_rstn
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W  = $clog2(GAP_BITS + 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ACK     = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_RESP,
    S_GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              sdp_ck_reg;
  logic              sdp_do_reg, sdp_do_next;
  logic              ready_reg, ready_next;
  logic              is_wr_reg, is_wr_next;
  logic [70:0]       tx_sr_reg, tx_sr_next;
  logic [6:0]        bit_cnt_reg, bit_cnt_next;
  logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [33:0]       rx_sr_reg, rx_sr_next;
  logic [31:0]       resp_data_reg, resp_data_next;
  logic [1:0]        err_code_reg, err_code_next;

  logic        div_last;
  logic        fall_tick;
  logic [6:0]  tx_len;
  logic [6:0]  rx_last_idx;
  logic [34:0] rx_shift;
  logic        rx_ack;
  logic        rx_par_ok;
  logic        rx_stop;
  logic        req_unused;

  assign req_unused = mem_req.req_burst;

  assign div_last  = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  assign fall_tick = sdp_ck_reg && div_last;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt_reg <= '0;
      sdp_ck_reg  <= 1'b0;
    end else if (div_last) begin
      div_cnt_reg <= '0;
      sdp_ck_reg  <= ~sdp_ck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Read response is START, ack, data[31:0], prty, STOP; write is START, ack, prty, STOP.
  // rx_shift holds everything after START once the final bit is shifted in.
  assign tx_len      = is_wr_reg ? 7'd71 : 7'd35;
  assign rx_last_idx = is_wr_reg ? 7'd2 : 7'd34;
  assign rx_shift    = {rx_sr_reg, sdp_di};
  assign rx_ack      = is_wr_reg ? rx_shift[2] : rx_shift[34];
  assign rx_par_ok   = is_wr_reg ? (rx_shift[1] == rx_shift[2])
                                 : (rx_shift[1] == ^rx_shift[34:2]);
  assign rx_stop     = rx_shift[0];

  always_comb begin
    state_next     = state_reg;
    sdp_do_next    = sdp_do_reg;
    is_wr_next     = is_wr_reg;
    tx_sr_next     = tx_sr_reg;
    bit_cnt_next   = bit_cnt_reg;
    tcnt_next      = tcnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    rx_sr_next     = rx_sr_reg;
    resp_data_next = resp_data_reg;
    err_code_next  = err_code_reg;

    case (state_reg)
      S_IDLE: begin
        sdp_do_next = 1'b1;
        if (mem_req_valid && ready_reg) begin
          is_wr_next   = mem_req.req_type;
          bit_cnt_next = '0;
          state_next   = S_TX;
          if (mem_req.req_type) begin
            tx_sr_next = {1'b0, 1'b1, mem_req.req_addr, mem_req.req_mask, mem_req.req_data,
                          ^{1'b1, mem_req.req_addr, mem_req.req_mask, mem_req.req_data}};
          end else begin
            // Read frame is left-aligned so the MSB-first shift is the same for both.
            tx_sr_next = {1'b0, 1'b0, mem_req.req_addr, ^{1'b0, mem_req.req_addr}, 36'd0};
          end
        end
      end

      S_TX: begin
        if (fall_tick) begin
          if (bit_cnt_reg == tx_len) begin
            sdp_do_next = 1'b1;
            tcnt_next   = '0;
            state_next  = S_WAIT;
          end else begin
            sdp_do_next  = tx_sr_reg[70];
            tx_sr_next   = {tx_sr_reg[69:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 7'd1;
          end
        end
      end

      S_WAIT: begin
        sdp_do_next = 1'b1;
        if (fall_tick) begin
          if (!sdp_di) begin
            bit_cnt_next = '0;
            rx_sr_next   = '0;
            state_next   = S_RX;
          end else if (tcnt_reg >= TCNT_W'(TIMEOUT - 1)) begin
            tcnt_next      = TCNT_W'(TIMEOUT);
            err_code_next  = ERR_TIMEOUT;
            resp_data_next = '0;
            state_next     = S_RESP;
          end else begin
            tcnt_next = tcnt_reg + TCNT_W'(1);
          end
        end
      end

      S_RX: begin
        sdp_do_next = 1'b1;
        if (fall_tick) begin
          rx_sr_next   = rx_shift[33:0];
          bit_cnt_next = bit_cnt_reg + 7'd1;
          if (bit_cnt_reg == rx_last_idx) begin
            state_next     = S_RESP;
            resp_data_next = '0;
            if (rx_ack) begin
              err_code_next = ERR_ACK;
            end else if (!rx_par_ok || !rx_stop) begin
              err_code_next = ERR_FRAME;
            end else begin
              err_code_next  = ERR_OK;
              resp_data_next = is_wr_reg ? 32'd0 : rx_shift[33:2];
            end
          end
        end
      end

      S_RESP: begin
        sdp_do_next = 1'b1;
        if (mem_resp_ready) begin
          resp_data_next = '0;
          err_code_next  = ERR_OK;
          gap_cnt_next   = '0;
          state_next     = S_GAP;
        end
      end

      S_GAP: begin
        sdp_do_next = 1'b1;
        if (fall_tick) begin
          if (gap_cnt_reg == GAP_W'(GAP_BITS - 1)) begin
            state_next = S_IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
          end
        end
      end

      default: begin
        sdp_do_next = 1'b1;
        state_next  = S_IDLE;
      end
    endcase

    ready_next = (state_next == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= S_IDLE;
      sdp_do_reg    <= 1'b1;
      ready_reg     <= 1'b0;
      is_wr_reg     <= 1'b0;
      tx_sr_reg     <= '0;
      bit_cnt_reg   <= '0;
      tcnt_reg      <= '0;
      gap_cnt_reg   <= '0;
      rx_sr_reg     <= '0;
      resp_data_reg <= '0;
      err_code_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      sdp_do_reg    <= sdp_do_next;
      ready_reg     <= ready_next;
      is_wr_reg     <= is_wr_next;
      tx_sr_reg     <= tx_sr_next;
      bit_cnt_reg   <= bit_cnt_next;
      tcnt_reg      <= tcnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      rx_sr_reg     <= rx_sr_next;
      resp_data_reg <= resp_data_next;
      err_code_reg  <= err_code_next;
    end
  end

  assign mem_req_ready      = ready_reg;
  assign mem_resp_valid     = (state_reg == S_RESP);
  assign mem_resp.resp_data = resp_data_reg;
  assign err_code           = err_code_reg;
  assign resp_err           = (err_code_reg != ERR_OK);
  assign sdp_ck             = sdp_ck_reg;
  assign sdp_do             = sdp_do_reg;
  assign sdp_rstn           = rstn_i;

endmodule

// File: tb/tb_mem2sdp.sv
// Directed bench for mem2sdp: a behavioural SDP target captures command frames
// and returns configurable responses (ok, bad parity, ACK error, silent).

module tb_mem2sdp;
  import mem2sdp_pkg::*;

  logic       clk_i          = 1'b0;
  logic       rstn_i         = 1'b0;
  logic       mem_req_valid  = 1'b0;
  logic       mem_req_ready;
  mem_req_t   mem_req        = '0;
  logic       mem_resp_valid;
  logic       mem_resp_ready = 1'b0;
  mem_resp_t  mem_resp;
  logic       resp_err;
  logic [1:0] err_code;
  logic       sdp_ck;
  logic       sdp_do;
  logic       sdp_di         = 1'b1;
  logic       sdp_rstn;

  int checks   = 0;
  int failures = 0;
  int txn_id   = 0;

  // target model controls and capture
  logic        tgt_ack    = 1'b0;
  logic        tgt_flip   = 1'b0;
  logic        tgt_silent = 1'b0;
  logic [31:0] tgt_data   = 32'd0;
  int          tstate     = 0;
  int          nbits      = 0;
  int          rleft      = 0;
  int          frame_cnt  = 0;
  int          last_len   = 0;
  logic        cmd_bit    = 1'b0;
  logic [70:0] cap        = '0;
  logic [70:0] last_frame = '0;
  logic [35:0] resp_sr    = '0;

  mem2sdp #(
    .CLK_DIV (2),
    .TIMEOUT (16),
    .GAP_BITS(4)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req       (mem_req),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp      (mem_resp),
    .resp_err      (resp_err),
    .err_code      (err_code),
    .sdp_ck        (sdp_ck),
    .sdp_do        (sdp_do),
    .sdp_di        (sdp_di),
    .sdp_rstn      (sdp_rstn)
  );

  always #5 clk_i = ~clk_i;

  // Target samples sdp_do on sdp_ck rising and drives sdp_di after sdp_ck falling.
  always @(posedge sdp_ck or negedge sdp_ck or negedge rstn_i) begin
    if (!rstn_i) begin
      tstate = 0;
      nbits  = 0;
      sdp_di = 1'b1;
    end else if (sdp_ck) begin
      if (tstate == 0) begin
        if (sdp_do == 1'b0) begin
          tstate = 1;
          nbits  = 1;
          cap    = '0;
        end
      end else if (tstate == 1) begin
        cap = {cap[69:0], sdp_do};
        nbits++;
        if (nbits == 2) cmd_bit = sdp_do;
        if (nbits == (cmd_bit ? 71 : 35)) begin
          last_frame = cap;
          last_len   = nbits;
          frame_cnt++;
          if (cmd_bit)
            resp_sr = {1'b0, tgt_ack, tgt_ack ^ tgt_flip, 1'b1, 32'd0};
          else
            resp_sr = {1'b0, tgt_ack, tgt_data, (^{tgt_ack, tgt_data}) ^ tgt_flip, 1'b1};
          rleft  = cmd_bit ? 4 : 36;
          tstate = tgt_silent ? 0 : 2;
        end
      end
    end else begin
      if (tstate == 2) begin
        sdp_di  = resp_sr[35];
        resp_sr = {resp_sr[34:0], 1'b0};
        rleft--;
        if (rleft == 0) tstate = 3;
      end else if (tstate == 3) begin
        sdp_di = 1'b1;
        tstate = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data);
    int n = 0;
    @(posedge clk_i); #1;
    mem_req.req_type  = wr;
    mem_req.req_addr  = addr;
    mem_req.req_mask  = mask;
    mem_req.req_data  = data;
    mem_req.req_burst = 1'b0;
    mem_req_valid     = 1'b1;
    while (!mem_req_ready && n < 1000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_val("req_accept", 128'(n < 1000), 128'(1));
    @(posedge clk_i); #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!mem_resp_valid && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_val("resp_wait", 128'(n < 3000), 128'(1));
  endtask

  task automatic end_resp();
    mem_resp_ready = 1'b1;
    @(posedge clk_i); #1;
    mem_resp_ready = 1'b0;
    check_val("resp_drop", 128'(mem_resp_valid), 128'(0));
  endtask

  task automatic log_txn(input string tag);
    txn_id++;
    $display("txn %0d %s: frame_len=%0d err_code=%0d resp_err=%0b resp_data=%h",
             txn_id, tag, last_len, err_code, resp_err, mem_resp.resp_data);
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data,
                         input logic [70:0] exp_frame, input int exp_len,
                         input logic [1:0] exp_err, input logic [31:0] exp_data);
    issue_req(wr, addr, mask, data);
    wait_resp();
    check_val({tag, "_frame"}, 128'(last_frame), 128'(exp_frame));
    check_val({tag, "_len"}, 128'(last_len), 128'(exp_len));
    check_val({tag, "_err_code"}, 128'(err_code), 128'(exp_err));
    check_val({tag, "_resp_err"}, 128'(resp_err), 128'(exp_err != 2'd0));
    check_val({tag, "_data"}, 128'(mem_resp.resp_data), 128'(exp_data));
    log_txn(tag);
    end_resp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   fc;
    logic held;
    logic seen;

    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_ready", 128'(mem_req_ready), 128'(0));
    check_val("rst_valid", 128'(mem_resp_valid), 128'(0));
    check_val("rst_resp_err", 128'(resp_err), 128'(0));
    check_val("rst_err_code", 128'(err_code), 128'(0));
    check_val("rst_data", 128'(mem_resp.resp_data), 128'(0));
    check_val("rst_sdp_ck", 128'(sdp_ck), 128'(0));
    check_val("rst_sdp_do", 128'(sdp_do), 128'(1));
    check_val("rst_sdp_rstn", 128'(sdp_rstn), 128'(0));
    rstn_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("idle_ready", 128'(mem_req_ready), 128'(1));
    check_val("idle_sdp_rstn", 128'(sdp_rstn), 128'(1));

    // plain write and read
    tgt_data = 32'h12345678;
    run_txn("wr0", 1'b1, 32'h1000_0004, 4'hF, 32'hDEADBEEF,
            {1'b0, 1'b1, 32'h1000_0004, 4'hF, 32'hDEADBEEF, 1'b1}, 71, 2'd0, 32'd0);
    run_txn("rd0", 1'b0, 32'h0000_0010, 4'h0, 32'd0,
            71'({2'b00, 32'h0000_0010, 1'b1}), 35, 2'd0, 32'h12345678);

    // response error paths
    tgt_flip = 1'b1;
    run_txn("rd_par", 1'b0, 32'h0000_0014, 4'h0, 32'd0,
            71'({2'b00, 32'h0000_0014, 1'b0}), 35, 2'd2, 32'd0);
    run_txn("wr_par", 1'b1, 32'h0000_0000, 4'h0, 32'd0,
            {1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1}, 71, 2'd2, 32'd0);
    tgt_flip = 1'b0;
    tgt_ack  = 1'b1;
    run_txn("rd_ack", 1'b0, 32'h0000_0018, 4'h0, 32'd0,
            71'({2'b00, 32'h0000_0018, 1'b0}), 35, 2'd1, 32'd0);
    run_txn("wr_ack", 1'b1, 32'h0000_0008, 4'h1, 32'h0000_0001,
            {1'b0, 1'b1, 32'h8, 4'h1, 32'h1, 1'b0}, 71, 2'd1, 32'd0);
    tgt_flip = 1'b1;
    run_txn("rd_ackpar", 1'b0, 32'h0000_001C, 4'h0, 32'd0,
            71'({2'b00, 32'h0000_001C, 1'b1}), 35, 2'd1, 32'd0);
    tgt_flip = 1'b0;
    tgt_ack  = 1'b0;

    // silent target: WAIT counts 16 fall ticks after the TX->WAIT tick
    tgt_silent = 1'b1;
    fc = frame_cnt;
    issue_req(1'b0, 32'h0000_0044, 4'h0, 32'd0);
    n = 0;
    while (frame_cnt == fc && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_val("to_frame", 128'(last_frame), 128'({2'b00, 32'h0000_0044, 1'b0}));
    n = 0;
    while (n < 100) begin
      @(negedge sdp_ck); #1;
      n++;
      if (mem_resp_valid) break;
    end
    check_val("to_ticks", 128'(n), 128'(17));
    check_val("to_err_code", 128'(err_code), 128'(3));
    check_val("to_resp_err", 128'(resp_err), 128'(1));
    check_val("to_data", 128'(mem_resp.resp_data), 128'(0));
    log_txn("timeout");
    end_resp();
    tgt_silent = 1'b0;

    // response held while mem_resp_ready stays low
    tgt_data = 32'hA5A5_0F0F;
    issue_req(1'b0, 32'h0000_0080, 4'h0, 32'd0);
    wait_resp();
    held = 1'b1;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (!mem_resp_valid || mem_resp.resp_data !== 32'hA5A5_0F0F || err_code !== 2'd0)
        held = 1'b0;
    end
    check_val("hold_stable", 128'(held), 128'(1));
    check_val("hold_data", 128'(mem_resp.resp_data), 128'(32'hA5A5_0F0F));
    check_val("hold_frame", 128'(last_frame), 128'({2'b00, 32'h0000_0080, 1'b1}));
    log_txn("hold");

    // back-to-back: next request already valid when the response is taken
    mem_req.req_type  = 1'b1;
    mem_req.req_addr  = 32'h0000_0020;
    mem_req.req_mask  = 4'h3;
    mem_req.req_data  = 32'h0000_00FF;
    mem_req.req_burst = 1'b0;
    mem_req_valid     = 1'b1;
    mem_resp_ready    = 1'b1;
    @(posedge clk_i); #1;
    mem_resp_ready = 1'b0;
    check_val("b2b_drop", 128'(mem_resp_valid), 128'(0));
    n = 0;
    while (n < 100) begin
      @(negedge sdp_ck); #1;
      n++;
      if (sdp_do == 1'b0) break;
    end
    mem_req_valid = 1'b0;
    check_val("gap_ticks", 128'(n), 128'(5));
    wait_resp();
    check_val("b2b_frame", 128'(last_frame),
              128'({1'b0, 1'b1, 32'h0000_0020, 4'h3, 32'h0000_00FF, 1'b0}));
    check_val("b2b_err_code", 128'(err_code), 128'(0));
    check_val("b2b_data", 128'(mem_resp.resp_data), 128'(0));
    log_txn("b2b_wr");
    end_resp();

    // reset in the middle of a write frame
    issue_req(1'b1, 32'h1000_0004, 4'hF, 32'hDEADBEEF);
    n = 0;
    while (nbits != 40 && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_val("rst_bit40", 128'(nbits), 128'(40));
    rstn_i = 1'b0;
    #1;
    check_val("mid_rst_sdp_do", 128'(sdp_do), 128'(1));
    check_val("mid_rst_sdp_ck", 128'(sdp_ck), 128'(0));
    check_val("mid_rst_ready", 128'(mem_req_ready), 128'(0));
    check_val("mid_rst_valid", 128'(mem_resp_valid), 128'(0));
    check_val("mid_rst_sdp_rstn", 128'(sdp_rstn), 128'(0));
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk_i); #1;
      if (mem_resp_valid) seen = 1'b1;
    end
    check_val("rst_no_resp", 128'(seen), 128'(0));
    tgt_data = 32'h0BAD_F00D;
    run_txn("rd_post", 1'b0, 32'h0000_0010, 4'h0, 32'd0,
            71'({2'b00, 32'h0000_0010, 1'b1}), 35, 2'd0, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
